spectrum_power_integrator: RTL and testbench

SPECTRUM_POWER_INTEGRATOR -- requirements
Module: spectrum_power_integrator

---
 rtl/frb_pkg.sv | 38 +++
 rtl/power_lane.sv | 24 ++
 rtl/spectrum_power_integrator.sv | 200 ++++++++++++++++++++
 tb/tb_spectrum_power_integrator.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frb_pkg.sv
// rtl/frb_pkg.sv - shared types and width derivations for the spectrum power integrator
package frb_pkg;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_RUN      = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // Counter width that never collapses to zero bits for single-beat spectra.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : clog2(n);
    endfunction

    function automatic int beats(input int nof_channel, input int nof_parallel);
        return nof_channel / nof_parallel;
    endfunction

    function automatic int power_width(input int data_width);
        return 2 * data_width + 1;
    endfunction

    function automatic int acc_width(input int data_width, input int nof_integ_max);
        return power_width(data_width) + clog2(nof_integ_max);
    endfunction

endpackage

// File: rtl/power_lane.sv
// rtl/power_lane.sv - registered re*re + im*im for one lane, two cycles
module power_lane #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                          clk_data,
    input  logic signed [DATA_WIDTH-1:0]  re_i,
    input  logic signed [DATA_WIDTH-1:0]  im_i,
    output logic [2*DATA_WIDTH:0]         power_o
);

    logic signed [2*DATA_WIDTH-1:0] sq_re_q;
    logic signed [2*DATA_WIDTH-1:0] sq_im_q;
    logic [2*DATA_WIDTH:0]          power_q;

    // Squares are never negative, so the extra sum bit holds the (-max,-max) case exactly.
    always_ff @(posedge clk_data) begin
        sq_re_q <= re_i * re_i;
        sq_im_q <= im_i * im_i;
        power_q <= {1'b0, sq_re_q} + {1'b0, sq_im_q};
    end

    assign power_o = power_q;

endmodule

// File: rtl/spectrum_power_integrator.sv
// rtl/spectrum_power_integrator.sv - per-channel power integration over a programmable number of spectra
module spectrum_power_integrator #(
    parameter int NOF_PARALLEL_SAMPLES = 16,
    parameter int DATA_WIDTH           = 16,
    parameter int NOF_CHANNEL          = 64,
    parameter int NOF_INTEG_MAX        = 256,
    parameter int ACC_WIDTH            = frb_pkg::acc_width(DATA_WIDTH, NOF_INTEG_MAX)
) (
    input  logic                                        clk_data,
    input  logic                                        rst,
    input  logic [NOF_PARALLEL_SAMPLES*DATA_WIDTH-1:0]  data_in_real,
    input  logic [NOF_PARALLEL_SAMPLES*DATA_WIDTH-1:0]  data_in_imag,
    input  logic                                        data_in_valid,
    input  logic                                        data_in_sof,
    input  logic [frb_pkg::clog2(NOF_INTEG_MAX):0]      integ_len,
    output logic [NOF_PARALLEL_SAMPLES*ACC_WIDTH-1:0]   data_out,
    output logic                                        data_out_valid,
    output logic                                        data_out_sof,
    output logic                                        frame_err
);
    import frb_pkg::*;

    localparam int NPS     = NOF_PARALLEL_SAMPLES;
    localparam int BEATS   = beats(NOF_CHANNEL, NOF_PARALLEL_SAMPLES);
    localparam int BEAT_W  = cnt_width(BEATS);
    localparam int LEN_W   = clog2(NOF_INTEG_MAX) + 1;
    localparam int PW      = power_width(DATA_WIDTH);
    localparam int LANES_W = NPS * ACC_WIDTH;

    state_t             state_q, state_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               frame_err_q, frame_err_d;

    logic               accept, restart, misplaced, drop, sample_len;
    logic               is_first, is_last;
    logic [BEAT_W-1:0]  cur_beat;
    logic [LEN_W-1:0]   cur_frame, cur_len, len_eff;

    always_ff @(posedge clk_data) begin
        if (rst) begin
            state_q     <= ST_UNLOCKED;
            beat_cnt_q  <= '0;
            frame_cnt_q <= '0;
            len_q       <= LEN_W'(1);
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            len_q       <= len_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Classify the incoming beat: where it lands in the integration and whether it is accepted.
    always_comb begin
        accept    = 1'b0;
        restart   = 1'b0;
        misplaced = 1'b0;
        drop      = 1'b0;
        if (integ_len == '0) begin
            len_eff = LEN_W'(1);
        end else if (integ_len > LEN_W'(NOF_INTEG_MAX)) begin
            len_eff = LEN_W'(NOF_INTEG_MAX);
        end else begin
            len_eff = integ_len;
        end
        if (data_in_valid) begin
            unique case (state_q)
                ST_UNLOCKED: begin
                    accept  = data_in_sof;
                    restart = data_in_sof;
                end
                ST_RUN: begin
                    if (beat_cnt_q == '0) begin
                        accept = data_in_sof;
                        drop   = !data_in_sof;
                    end else begin
                        accept    = 1'b1;
                        restart   = data_in_sof;
                        misplaced = data_in_sof;
                    end
                end
                default: ;
            endcase
        end
        cur_beat   = restart ? '0 : beat_cnt_q;
        cur_frame  = restart ? '0 : frame_cnt_q;
        sample_len = (cur_beat == '0) && (cur_frame == '0);
        cur_len    = sample_len ? len_eff : len_q;
        is_first   = (cur_frame == '0);
        is_last    = (cur_frame == cur_len - LEN_W'(1));
    end

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        frame_cnt_d = frame_cnt_q;
        len_d       = len_q;
        frame_err_d = frame_err_q | misplaced | drop;
        if (accept) begin
            state_d = ST_RUN;
            if (sample_len) begin
                len_d = len_eff;
            end
            if (cur_beat == BEAT_W'(BEATS - 1)) begin
                beat_cnt_d  = '0;
                frame_cnt_d = is_last ? '0 : cur_frame + LEN_W'(1);
            end else begin
                beat_cnt_d  = cur_beat + BEAT_W'(1);
                frame_cnt_d = cur_frame;
            end
        end else if (drop) begin
            state_d     = ST_UNLOCKED;
            beat_cnt_d  = '0;
            frame_cnt_d = '0;
        end
    end

    logic [NPS*DATA_WIDTH-1:0] re_q, im_q;
    logic [2:0]                vld_pipe_q, first_pipe_q, last_pipe_q;
    logic [BEAT_W-1:0]         beat_pipe_q [3];
    logic [NPS*PW-1:0]         power_w;

    always_ff @(posedge clk_data) begin
        re_q           <= data_in_real;
        im_q           <= data_in_imag;
        first_pipe_q   <= {first_pipe_q[1:0], is_first};
        last_pipe_q    <= {last_pipe_q[1:0], is_last};
        beat_pipe_q[0] <= cur_beat;
        beat_pipe_q[1] <= beat_pipe_q[0];
        beat_pipe_q[2] <= beat_pipe_q[1];
    end

    always_ff @(posedge clk_data) begin
        if (rst) begin
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[1:0], accept};
        end
    end

    for (genvar n = 0; n < NPS; n++) begin : g_lane
        power_lane #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_power_lane (
            .clk_data(clk_data),
            .re_i    (re_q[n*DATA_WIDTH +: DATA_WIDTH]),
            .im_i    (im_q[n*DATA_WIDTH +: DATA_WIDTH]),
            .power_o (power_w[n*PW +: PW])
        );
    end

    logic [LANES_W-1:0] acc_q [BEATS];
    logic [LANES_W-1:0] acc_rd;
    logic [LANES_W-1:0] sum_d;

    assign acc_rd = acc_q[beat_pipe_q[2]];

    // Frame 0 starts fresh from p, so stale contents never need clearing.
    always_comb begin
        sum_d = '0;
        for (int n = 0; n < NPS; n++) begin
            sum_d[n*ACC_WIDTH +: ACC_WIDTH] =
                (first_pipe_q[2] ? '0 : acc_rd[n*ACC_WIDTH +: ACC_WIDTH])
                + ACC_WIDTH'(power_w[n*PW +: PW]);
        end
    end

    always_ff @(posedge clk_data) begin
        if (vld_pipe_q[2] && !last_pipe_q[2]) begin
            acc_q[beat_pipe_q[2]] <= sum_d;
        end
    end

    logic [LANES_W-1:0] data_out_q;
    logic               out_valid_q, out_sof_q;

    always_ff @(posedge clk_data) begin
        if (rst) begin
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
        end else begin
            out_valid_q <= vld_pipe_q[2] && last_pipe_q[2];
            out_sof_q   <= vld_pipe_q[2] && last_pipe_q[2] && (beat_pipe_q[2] == '0);
            if (vld_pipe_q[2] && last_pipe_q[2]) begin
                data_out_q <= sum_d;
            end
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = out_valid_q;
    assign data_out_sof   = out_sof_q;
    assign frame_err      = frame_err_q;

endmodule

// File: tb/tb_spectrum_power_integrator.sv
// tb/tb_spectrum_power_integrator.sv - randomized self-checking bench against a spectrum-level power model
module tb_spectrum_power_integrator;

    localparam int NPS   = 16;
    localparam int DW    = 16;
    localparam int NCH   = 64;
    localparam int BEATS = NCH / NPS;
    localparam int ACCW  = 41;
    localparam int LW    = 9;
    localparam int OW    = NPS * ACCW;

    logic              clk_data = 1'b0;
    logic              rst = 1'b1;
    logic [NPS*DW-1:0] data_in_real = '0;
    logic [NPS*DW-1:0] data_in_imag = '0;
    logic              data_in_valid = 1'b0;
    logic              data_in_sof = 1'b0;
    logic [LW-1:0]     integ_len = LW'(1);
    logic [OW-1:0]     data_out;
    logic              data_out_valid;
    logic              data_out_sof;
    logic              frame_err;

    spectrum_power_integrator dut (
        .clk_data      (clk_data),
        .rst           (rst),
        .data_in_real  (data_in_real),
        .data_in_imag  (data_in_imag),
        .data_in_valid (data_in_valid),
        .data_in_sof   (data_in_sof),
        .integ_len     (integ_len),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_sof  (data_out_sof),
        .frame_err     (frame_err)
    );

    always #5 clk_data = ~clk_data;

    int cyc = 0;
    always @(posedge clk_data) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;

    typedef struct {
        int          cyc;
        logic        sof;
        logic [OW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    logic signed [DW-1:0] re_v [NPS];
    logic signed [DW-1:0] im_v [NPS];
    logic [LW-1:0]        len_v = LW'(1);

    // Spectrum-level model: per-channel running power totals over the frames of one integration.
    bit     m_locked = 0;
    int     m_pos = 0;
    int     m_frame = 0;
    int     m_len = 1;
    bit     m_err = 0;
    longint m_tot [NCH];

    function automatic int clamp_len(input int l);
        if (l == 0) return 1;
        if (l > 256) return 256;
        return l;
    endfunction

    task automatic model_reset();
        m_locked = 0;
        m_pos    = 0;
        m_frame  = 0;
        m_err    = 0;
        exp_q.delete();
    endtask

    task automatic model_beat(input bit v, input bit s, input int out_cyc);
        exp_t   e;
        longint r, i;
        if (!v) return;
        if (!m_locked) begin
            if (!s) return;
            m_locked = 1;
            m_pos    = 0;
            m_frame  = 0;
        end else if (s && m_pos != 0) begin
            m_err   = 1;
            m_pos   = 0;
            m_frame = 0;
        end else if (!s && m_pos == 0) begin
            m_err    = 1;
            m_locked = 0;
            m_frame  = 0;
            return;
        end
        if (m_pos == 0 && m_frame == 0) m_len = clamp_len(int'(len_v));
        for (int n = 0; n < NPS; n++) begin
            r = re_v[n];
            i = im_v[n];
            if (m_frame == 0) m_tot[m_pos*NPS+n] = 0;
            m_tot[m_pos*NPS+n] += r*r + i*i;
        end
        if (m_frame == m_len - 1) begin
            e.cyc  = out_cyc;
            e.sof  = (m_pos == 0);
            e.data = '0;
            for (int n = 0; n < NPS; n++) begin
                r = m_tot[m_pos*NPS+n];
                e.data[n*ACCW +: ACCW] = r[ACCW-1:0];
            end
            exp_q.push_back(e);
        end
        m_pos++;
        if (m_pos == BEATS) begin
            m_pos   = 0;
            m_frame = (m_frame == m_len - 1) ? 0 : m_frame + 1;
        end
    endtask

    logic [OW-1:0] hold_exp = '0;
    always @(negedge clk_data) begin
        exp_t e;
        if (rst) begin
            hold_exp = '0;
        end else if (data_out_valid) begin
            n_out++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_out: valid at cycle %0d lane0=%0d, required no output", cyc, data_out[ACCW-1:0]);
                hold_exp = data_out;
            end else begin
                e = exp_q.pop_front();
                if (data_out !== e.data || data_out_sof !== e.sof || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL out_beat: got cyc=%0d sof=%0b lane0=%0d lane15=%0d, required cyc=%0d sof=%0b lane0=%0d lane15=%0d",
                             cyc, data_out_sof, data_out[ACCW-1:0], data_out[15*ACCW +: ACCW],
                             e.cyc, e.sof, e.data[ACCW-1:0], e.data[15*ACCW +: ACCW]);
                end
                hold_exp = e.data;
            end
        end else begin
            n_cmp++;
            if (data_out !== hold_exp || data_out_sof !== 1'b0) begin
                n_bad++;
                $display("FAIL out_hold: cycle %0d lane0=%0d sof=%0b, required lane0=%0d sof=0", cyc, data_out[ACCW-1:0], data_out_sof, hold_exp[ACCW-1:0]);
            end
        end
    end

    task automatic drive(input bit v, input bit s);
        @(posedge clk_data);
        #1;
        for (int n = 0; n < NPS; n++) begin
            data_in_real[n*DW +: DW] = re_v[n];
            data_in_imag[n*DW +: DW] = im_v[n];
        end
        data_in_valid = v;
        data_in_sof   = s;
        integ_len     = len_v;
        model_beat(v, s, cyc + 4);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0);
    endtask

    task automatic set_const(input int re, input int im);
        for (int n = 0; n < NPS; n++) begin
            re_v[n] = DW'(re);
            im_v[n] = DW'(im);
        end
    endtask

    task automatic set_rand();
        for (int n = 0; n < NPS; n++) begin
            case ($urandom_range(0, 7))
                0:       re_v[n] = -16'sd32768;
                1:       re_v[n] = 16'sd32767;
                default: re_v[n] = DW'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       im_v[n] = -16'sd32768;
                1:       im_v[n] = 16'sd32767;
                default: im_v[n] = DW'($urandom);
            endcase
        end
    endtask

    task automatic send_spectrum(input int gap, input bit rnd);
        for (int b = 0; b < BEATS; b++) begin
            if (rnd) set_rand();
            drive(1'b1, b == 0);
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk_data);
        #1;
        rst = 1'b1;
        data_in_valid = 1'b0;
        data_in_sof   = 1'b0;
        model_reset();
        @(posedge clk_data);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(posedge clk_data);
        #1;
        rst = 1'b0;
        n_cmp += 4;
        if (data_out !== '0) begin n_bad++; $display("FAIL reset_data: got lane0=%0d, required 0", data_out[ACCW-1:0]); end
        if (data_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b, required 0", data_out_valid); end
        if (data_out_sof !== 1'b0) begin n_bad++; $display("FAIL reset_sof: got %0b, required 0", data_out_sof); end
        if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0b, required 0", frame_err); end
    endtask

    task automatic test_len1_const();
        int base;
        base  = n_out;
        len_v = LW'(1);
        set_const(3, 4);
        send_spectrum(0, 0);
        idle(8);
        n_cmp += 2;
        if (n_out - base != 4) begin n_bad++; $display("FAIL len1_count: got %0d beats, required 4", n_out - base); end
        if (data_out[5*ACCW +: ACCW] !== ACCW'(25)) begin n_bad++; $display("FAIL len1_value: got %0d, required 25", data_out[5*ACCW +: ACCW]); end
    endtask

    task automatic test_max_neg();
        int            base;
        logic [ACCW-1:0] want;
        want  = ACCW'(64'd8589934592);
        base  = n_out;
        len_v = LW'(4);
        set_const(-32768, -32768);
        repeat (3) send_spectrum(0, 0);
        idle(8);
        n_cmp++;
        if (n_out != base) begin n_bad++; $display("FAIL maxneg_early: got %0d beats before frame 4, required 0", n_out - base); end
        send_spectrum(0, 0);
        idle(8);
        n_cmp += 2;
        if (n_out - base != 4) begin n_bad++; $display("FAIL maxneg_count: got %0d beats, required 4", n_out - base); end
        if (data_out[11*ACCW +: ACCW] !== want) begin n_bad++; $display("FAIL maxneg_value: got %0d, required %0d", data_out[11*ACCW +: ACCW], want); end
    endtask

    task automatic test_gaps();
        int base;
        base  = n_out;
        len_v = LW'(2);
        repeat (2) send_spectrum(0, 1);
        repeat (2) send_spectrum(3, 1);
        idle(8);
        n_cmp++;
        if (n_out - base != 8) begin n_bad++; $display("FAIL gaps_count: got %0d beats, required 8", n_out - base); end
    endtask

    task automatic test_misplaced_sof();
        int base;
        base  = n_out;
        len_v = LW'(3);
        send_spectrum(0, 1);
        set_rand(); drive(1'b1, 1'b1);
        set_rand(); drive(1'b1, 1'b0);
        set_rand(); drive(1'b1, 1'b1);
        for (int b = 1; b < BEATS; b++) begin
            set_rand();
            drive(1'b1, 1'b0);
        end
        repeat (2) send_spectrum(0, 1);
        idle(8);
        n_cmp += 2;
        if (frame_err !== 1'b1) begin n_bad++; $display("FAIL misplaced_err: got %0b, required 1", frame_err); end
        if (n_out - base != 4) begin n_bad++; $display("FAIL misplaced_count: got %0d beats, required 4", n_out - base); end
        reset_pulse();
        n_cmp++;
        if (frame_err !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %0b, required 0", frame_err); end
    endtask

    task automatic test_reset_mid();
        int base;
        base  = n_out;
        len_v = LW'(4);
        repeat (2) send_spectrum(0, 1);
        set_rand(); drive(1'b1, 1'b1);
        set_rand(); drive(1'b1, 1'b0);
        reset_pulse();
        n_cmp += 2;
        if (data_out !== '0) begin n_bad++; $display("FAIL rstmid_data: got lane0=%0d, required 0", data_out[ACCW-1:0]); end
        if (data_out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %0b, required 0", data_out_valid); end
        for (int b = 0; b < BEATS; b++) begin
            set_rand();
            drive(1'b1, 1'b0);
        end
        idle(8);
        n_cmp += 2;
        if (n_out != base) begin n_bad++; $display("FAIL rstmid_quiet: got %0d beats, required 0", n_out - base); end
        if (frame_err !== 1'b0) begin n_bad++; $display("FAIL rstmid_err: got %0b, required 0", frame_err); end
        len_v = LW'(1);
        send_spectrum(1, 1);
        idle(8);
        n_cmp++;
        if (n_out - base != 4) begin n_bad++; $display("FAIL rstmid_relock: got %0d beats, required 4", n_out - base); end
    endtask

    task automatic test_len_clamp();
        int base;
        base  = n_out;
        len_v = LW'(0);
        send_spectrum(0, 1);
        idle(8);
        n_cmp++;
        if (n_out - base != 4) begin n_bad++; $display("FAIL len0_count: got %0d beats, required 4", n_out - base); end
        base  = n_out;
        len_v = LW'(300);
        repeat (255) send_spectrum(0, 1);
        idle(8);
        n_cmp++;
        if (n_out != base) begin n_bad++; $display("FAIL len300_early: got %0d beats after 255 spectra, required 0", n_out - base); end
        send_spectrum(0, 1);
        idle(8);
        n_cmp++;
        if (n_out - base != 4) begin n_bad++; $display("FAIL len300_count: got %0d beats, required 4", n_out - base); end
    endtask

    task automatic test_back_to_back();
        int gen_pos;
        bit s;
        gen_pos = 0;
        for (int k = 0; k < 400; k++) begin
            if (gen_pos == 0 && $urandom_range(0, 3) == 0) len_v = LW'($urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                s = (gen_pos == 0);
                if ($urandom_range(0, 39) == 0) s = !s;
                set_rand();
                drive(1'b1, s);
                gen_pos = (gen_pos + 1) % BEATS;
            end
        end
        idle(10);
        n_cmp += 2;
        if (frame_err !== m_err) begin n_bad++; $display("FAIL b2b_err: got %0b, required %0b", frame_err, m_err); end
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL b2b_drain: got %0d beats still expected, required 0", exp_q.size()); end
    endtask

    initial begin
        set_const(0, 0);
        test_reset();
        test_len1_const();
        test_max_neg();
        test_gaps();
        test_misplaced_sof();
        test_reset_mid();
        test_len_clamp();
        reset_pulse();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
